reg_file_sb: RTL
================

Name: reg_file_sb

Overview:
Parametrised multi-read-port integer register file with a built-in busy-bit scoreboard for the pipelined core.
- Registers are written from the writeback stage.
- Each read port returns operand data plus a busy flag.
- A destination is marked pending when an instruction issues, and cleared on its writeback.
- issue_ready gates decode; it drops on RAW or WAW hazards.
- Register 0 is hardwired to zero and is never busy.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of 2, >=2)
NREAD, 2, number of read ports (1..4)
AW, $clog2(NREGS), register address width (derived, localparam)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
rs_addr  in  NREAD*AW  read addresses, port i at [i*AW +: AW]
rs_data  out  NREAD*XLEN  read data, port i at [i*XLEN +: XLEN], combinational
rs_busy  out  NREAD  port i source has a pending write not resolvable this cycle
issue_valid  in  1  decode presents an instruction
issue_rd  in  AW  destination of issuing instruction
issue_uses  in  NREAD  port i operand actually used by issuing instruction
issue_ready  out  1  instruction may issue this cycle
wb_valid  in  1  writeback strobe
wb_rd  in  AW  writeback destination
wb_data  in  XLEN  writeback value
pending_cnt  out  AW+1  number of registers currently busy

Behaviour:
- Reset: when rst_n=0 at a clock edge, all registers go to 0, all busy bits clear, pending_cnt=0. Reset overrides every other input on that edge.
- Read (combinational):
  - address 0 -> data 0, busy 0.
  - otherwise data = reg[addr], except under bypass (see Optional Feature).
  - rs_busy[i] = busy[addr] && !(bypass hit).
- Write: on a clock edge with wb_valid && wb_rd!=0, reg[wb_rd] <= wb_data. Writes to register 0 are ignored.
- issue_ready = !(OR over i of issue_uses[i] && rs_busy[i]) && !(issue_rd!=0 && busy[issue_rd] && !(wb_valid && wb_rd==issue_rd)).
  - The last term is the WAW check, relaxed when that register is being written back in the same cycle.
  - issue_ready does not depend on issue_valid.
- Scoreboard update on a clock edge:
  - fire = issue_valid && issue_ready && issue_rd!=0.
  - wb_valid && wb_rd!=0 clears busy[wb_rd].
  - fire sets busy[issue_rd].
  - Same register both set and cleared on one edge: set wins, because the new producer is pending.
- Writeback to a register that is not busy: data is written, busy stays 0, no error.
- pending_cnt: registered popcount of the busy bits. It changes by -1, 0 or +1 per cycle, and never exceeds NREGS-1.
- No state machine beyond per-register busy bits; all state changes are single-cycle.

Optional Feature:
REG_FILE_BYPASS_EN
- Defined: a read address matching wb_rd while wb_valid is high (address !=0) returns wb_data in the same cycle, and its rs_busy is 0.
- Undefined: reads return stored reg[] only. A source being written back this cycle still reports busy and gets the new value one cycle later.
  - Hence issue latency after a writeback is 1 cycle with the feature, 2 without.

Decomposition:
- Package rv_pkg: XLEN, NREGS, REG_AW localparams; typedefs reg_addr_t (logic [REG_AW-1:0]) and xlen_t (logic [XLEN-1:0]).
- Sub-module reg_scoreboard: holds the busy vector and pending_cnt, and computes the set/clear priority.
- reg_file_sb holds the storage array, read muxing/bypass, and issue_ready.

Test Plan:
1. Reset, then read ports 0/1 at x5/x0 -> rs_data=0/0, rs_busy=0/0, pending_cnt=0, issue_ready=1.
2. Issue rd=x3, then next cycle read x3 with issue_uses=01 -> rs_busy[0]=1, issue_ready=0, pending_cnt=1. Then wb x3=0xDEADBEEF:
   - REG_FILE_BYPASS_EN: rs_data=0xDEADBEEF and issue_ready=1 in that cycle.
   - Without it: the same results one cycle later.
3. Same edge: issue rd=x7 while wb x7=0x1234 with x7 previously busy -> x7 stays busy, reg x7=0x1234, pending_cnt unchanged.
4. wb x0=0xFFFFFFFF and issue rd=x0 -> read x0=0, busy[0]=0, pending_cnt unchanged.
5. Issue x1..x31 back to back with no writebacks -> pending_cnt=31. Then reissue x4 -> issue_ready=0 (WAW). Then wb x4 same cycle -> issue_ready=1.
6. Busy x9, drive rst_n=0 for one cycle during a pending wb x9=0x55 -> after the edge x9=0, busy clear, pending_cnt=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared core widths and register-file types; the register file takes these as its default parameters.
package rv_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = $clog2(NREGS);

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xlen_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits plus a registered count of busy registers; one-cycle update, no backpressure.
// A set and a clear of the same register on one edge leaves it busy (the new producer is pending).
module reg_scoreboard #(
    parameter int NREGS = rv_pkg::NREGS,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_vld_i,
    input  logic [AW-1:0]    set_rd_i,
    input  logic             clr_vld_i,
    input  logic [AW-1:0]    clr_rd_i,
    output logic [NREGS-1:0] busy_o,
    output logic [AW:0]      pending_cnt_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;
    logic             set_hit;
    logic             clr_hit;
    logic             cnt_inc;
    logic             cnt_dec;

    assign set_hit = set_vld_i && (set_rd_i != '0);
    assign clr_hit = clr_vld_i && (clr_rd_i != '0);

    always_comb begin
        busy_d = busy_q;
        if (clr_hit) begin
            busy_d[clr_rd_i] = 1'b0;
        end
        if (set_hit) begin
            busy_d[set_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Count tracks busy_d incrementally: a clear is cancelled when the same register is re-set.
    assign cnt_inc = set_hit && !busy_q[set_rd_i];
    assign cnt_dec = clr_hit && busy_q[clr_rd_i] && !(set_hit && (set_rd_i == clr_rd_i));

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc && !cnt_dec) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (cnt_dec && !cnt_inc) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o        = busy_q;
    assign pending_cnt_o = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with busy-bit scoreboard; combinational reads, issue_ready stalls decode on RAW/WAW.
// REG_FILE_BYPASS_EN forwards same-cycle writeback data to the read ports and hides their busy flag.
module reg_file_sb #(
    parameter int XLEN  = rv_pkg::XLEN,
    parameter int NREGS = rv_pkg::NREGS,
    parameter int NREAD = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREAD*AW-1:0]   rs_addr,
    output logic [NREAD*XLEN-1:0] rs_data,
    output logic [NREAD-1:0]      rs_busy,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_rd,
    input  logic [NREAD-1:0]      issue_uses,
    output logic                  issue_ready,
    input  logic                  wb_valid,
    input  logic [AW-1:0]         wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    output logic [AW:0]           pending_cnt
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic             wb_hit;
    logic             raw_hzd;
    logic             waw_hzd;
    logic             issue_fire;

    assign wb_hit = wb_valid && (wb_rd != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else if (wb_hit) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0] addr;
        logic          byp_hit;

        assign addr = rs_addr[i*AW +: AW];
`ifdef REG_FILE_BYPASS_EN
        assign byp_hit = wb_hit && (wb_rd == addr);
`else
        assign byp_hit = 1'b0;
`endif
        assign rs_data[i*XLEN +: XLEN] = (addr == '0) ? '0 :
                                         byp_hit      ? wb_data : regs_q[addr];
        assign rs_busy[i] = busy_q[addr] && !byp_hit;
    end

    assign raw_hzd = |(issue_uses & rs_busy);
    // A destination being retired this cycle may be reclaimed by the next producer.
    assign waw_hzd = (issue_rd != '0) && busy_q[issue_rd] &&
                     !(wb_valid && (wb_rd == issue_rd));

    assign issue_ready = !raw_hzd && !waw_hzd;
    assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);

    reg_scoreboard #(
        .NREGS (NREGS)
    ) u_sb (
        .clk           (clk),
        .rst_n         (rst_n),
        .set_vld_i     (issue_fire),
        .set_rd_i      (issue_rd),
        .clr_vld_i     (wb_valid),
        .clr_rd_i      (wb_rd),
        .busy_o        (busy_q),
        .pending_cnt_o (pending_cnt)
    );

endmodule
